// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Single-port byte-wide RAM arbiter between instruction fetch
//                (IF) and load/store (MEM). Serialises multi-byte accesses
//                one byte per cycle and assembles little-endian read data.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_request,
    input  logic [31:0] if_addr,
    input  logic        mem_request,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [1:0]  mem_len,
    input  logic [7:0]  ram_din,
    output logic [7:0]  ram_dout,
    output logic [31:0] ram_a,
    output logic        ram_wr,
    output logic        busy,
    output logic [1:0]  if_or_mem_o,
    output logic [31:0] rdata,
    output logic [31:0] pc_back
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_read  = 2'd1;
    localparam logic [1:0] c_st_write = 2'd2;

    localparam logic [1:0] c_tag_if  = 2'b01;
    localparam logic [1:0] c_tag_mem = 2'b10;

    logic [1:0]  r_state;
    logic [31:0] r_base;
    logic [1:0]  r_cnt;        // index of the byte currently on the RAM port
    logic [1:0]  r_last;       // byte count minus one
    logic [31:0] r_wdata;
    logic        r_owner_mem;
    logic [31:0] r_pc_next;
    logic [31:0] r_buf;        // read bytes gathered so far, upper lanes zero
    logic [31:0] r_rdata;
    logic [31:0] r_pc_back;
    logic [1:0]  r_tag;
    logic [31:0] r_ram_a;
    logic [7:0]  r_ram_dout;
    logic        r_ram_wr;

    logic [1:0]  w_cnt_nxt;
    logic [31:0] w_addr_nxt;
    logic [1:0]  w_mem_last;
    logic [31:0] w_buf_nxt;
    logic [7:0]  w_wbyte_nxt;

    assign w_cnt_nxt  = r_cnt + 2'd1;
    assign w_addr_nxt = r_base + {30'd0, w_cnt_nxt};
    // 00 -> 1 byte, 01 -> 2 bytes, 10/11 -> 4 bytes
    assign w_mem_last = mem_len[1] ? 2'd3 : {1'b0, mem_len[0]};

    // Merge the byte returned by the RAM into its lane of the read buffer
    always_comb begin
        w_buf_nxt = r_buf;
        case (r_cnt)
            2'd0:    w_buf_nxt[7:0]   = ram_din;
            2'd1:    w_buf_nxt[15:8]  = ram_din;
            2'd2:    w_buf_nxt[23:16] = ram_din;
            default: w_buf_nxt[31:24] = ram_din;
        endcase
    end

    // Select the store byte for the next write beat
    always_comb begin
        w_wbyte_nxt = 8'd0;
        case (w_cnt_nxt)
            2'd0:    w_wbyte_nxt = r_wdata[7:0];
            2'd1:    w_wbyte_nxt = r_wdata[15:8];
            2'd2:    w_wbyte_nxt = r_wdata[23:16];
            default: w_wbyte_nxt = r_wdata[31:24];
        endcase
    end

    // Arbitration, byte sequencing and completion; all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_base      <= 32'd0;
            r_cnt       <= 2'd0;
            r_last      <= 2'd0;
            r_wdata     <= 32'd0;
            r_owner_mem <= 1'b0;
            r_pc_next   <= 32'd0;
            r_buf       <= 32'd0;
            r_rdata     <= 32'd0;
            r_pc_back   <= 32'd0;
            r_tag       <= 2'b00;
            r_ram_a     <= 32'd0;
            r_ram_dout  <= 8'd0;
            r_ram_wr    <= 1'b0;
        end else begin
            r_tag <= 2'b00;
            case (r_state)
                c_st_idle: begin
                    // MEM has priority; requests are only looked at here
                    if (mem_request) begin
                        r_base      <= mem_addr;
                        r_last      <= w_mem_last;
                        r_wdata     <= mem_wdata;
                        r_owner_mem <= 1'b1;
                        r_cnt       <= 2'd0;
                        r_buf       <= 32'd0;
                        r_ram_a     <= mem_addr;
                        if (mem_we) begin
                            r_state    <= c_st_write;
                            r_ram_wr   <= 1'b1;
                            r_ram_dout <= mem_wdata[7:0];
                        end else begin
                            r_state <= c_st_read;
                        end
                    end else if (if_request) begin
                        r_base      <= if_addr;
                        r_last      <= 2'd3;
                        r_owner_mem <= 1'b0;
                        r_pc_next   <= if_addr + 32'd4;
                        r_cnt       <= 2'd0;
                        r_buf       <= 32'd0;
                        r_ram_a     <= if_addr;
                        r_state     <= c_st_read;
                    end
                end
                c_st_read: begin
                    r_buf <= w_buf_nxt;
                    if (r_cnt == r_last) begin
                        r_rdata <= w_buf_nxt;
                        r_tag   <= r_owner_mem ? c_tag_mem : c_tag_if;
                        if (!r_owner_mem) begin
                            r_pc_back <= r_pc_next;
                        end
                        r_ram_a <= 32'd0;
                        r_state <= c_st_idle;
                    end else begin
                        r_cnt   <= w_cnt_nxt;
                        r_ram_a <= w_addr_nxt;
                    end
                end
                c_st_write: begin
                    if (r_cnt == r_last) begin
                        r_ram_wr   <= 1'b0;
                        r_ram_a    <= 32'd0;
                        r_ram_dout <= 8'd0;
                        r_tag      <= c_tag_mem;
                        r_state    <= c_st_idle;
                    end else begin
                        r_cnt      <= w_cnt_nxt;
                        r_ram_a    <= w_addr_nxt;
                        r_ram_dout <= w_wbyte_nxt;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign ram_dout    = r_ram_dout;
    assign ram_a       = r_ram_a;
    assign ram_wr      = r_ram_wr;
    assign busy        = (r_state != c_st_idle);
    assign if_or_mem_o = r_tag;
    assign rdata       = r_rdata;
    assign pc_back     = r_pc_back;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Directed self-checking bench for mem_arbiter with a small
//                combinational RAM model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_request;
    logic [31:0] if_addr;
    logic        mem_request;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_len;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;
    logic        busy;
    logic [1:0]  if_or_mem_o;
    logic [31:0] rdata;
    logic [31:0] pc_back;

    int n_vec;
    int n_err;

    mem_arbiter u_dut (
        .clk         (clk),
        .rst         (rst),
        .if_request  (if_request),
        .if_addr     (if_addr),
        .mem_request (mem_request),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_len     (mem_len),
        .ram_din     (ram_din),
        .ram_dout    (ram_dout),
        .ram_a       (ram_a),
        .ram_wr      (ram_wr),
        .busy        (busy),
        .if_or_mem_o (if_or_mem_o),
        .rdata       (rdata),
        .pc_back     (pc_back)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM contents seen by the arbiter for the current address
    function automatic logic [7:0] ram_byte(input logic [31:0] a);
        case (a)
            32'h0000_1000: ram_byte = 8'h13;
            32'h0000_1001: ram_byte = 8'h05;
            32'h0000_1002: ram_byte = 8'h10;
            32'h0000_1003: ram_byte = 8'h00;
            32'h0000_0020: ram_byte = 8'hAB;
            32'hFFFF_FFFE: ram_byte = 8'h11;
            32'hFFFF_FFFF: ram_byte = 8'h22;
            32'h0000_0000: ram_byte = 8'h33;
            32'h0000_0001: ram_byte = 8'h44;
            32'h0000_0040: ram_byte = 8'h5A;
            default:       ram_byte = 8'hEE;
        endcase
    endfunction

    always_comb ram_din = ram_byte(ram_a);

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        rst         = 1'b1;
        if_request  = 1'b1;          // held through reset, must not be taken
        if_addr     = 32'h0000_1000;
        mem_request = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = 32'd0;
        mem_wdata   = 32'd0;
        mem_len     = 2'b00;

        // ---------------- reset state
        tick();
        tick();
        check_eq("rst_busy",  {31'd0, busy},       32'd0);
        check_eq("rst_tag",   {30'd0, if_or_mem_o}, 32'd0);
        check_eq("rst_rdata", rdata,               32'd0);
        check_eq("rst_pc",    pc_back,             32'd0);
        check_eq("rst_ram_a", ram_a,               32'd0);
        check_eq("rst_wr",    {31'd0, ram_wr},     32'd0);
        check_eq("rst_dout",  {24'd0, ram_dout},   32'd0);

        // ---------------- IF fetch, accepted on the first edge out of reset
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq("if_busy", {31'd0, busy},   32'd1);
            check_eq("if_ram_a", ram_a,          32'h0000_1000 + k);
            check_eq("if_wr",   {31'd0, ram_wr}, 32'd0);
            check_eq("if_tag_q", {30'd0, if_or_mem_o}, 32'd0);
        end
        tick();
        check_eq("if_done_busy",  {31'd0, busy},        32'd0);
        check_eq("if_done_tag",   {30'd0, if_or_mem_o}, 32'd1);
        check_eq("if_done_rdata", rdata,                32'h0010_0513);
        check_eq("if_done_pc",    pc_back,              32'h0000_1004);
        check_eq("if_done_ram_a", ram_a,                32'd0);
        if_request = 1'b0;
        tick();
        check_eq("if_tag_clr", {30'd0, if_or_mem_o}, 32'd0);
        check_eq("if_idle",    {31'd0, busy},        32'd0);

        // ---------------- simultaneous requests: MEM byte load wins
        if_request  = 1'b1;
        if_addr     = 32'h0000_1000;
        mem_request = 1'b1;
        mem_we      = 1'b0;
        mem_addr    = 32'h0000_0020;
        mem_len     = 2'b00;
        tick();
        check_eq("arb_busy",  {31'd0, busy}, 32'd1);
        check_eq("arb_ram_a", ram_a,         32'h0000_0020);
        mem_request = 1'b0;
        tick();
        check_eq("arb_tag",   {30'd0, if_or_mem_o}, 32'd2);
        check_eq("arb_rdata", rdata,                32'h0000_00AB);
        check_eq("arb_busy0", {31'd0, busy},        32'd0);
        check_eq("arb_pc",    pc_back,              32'h0000_1004);
        tick();
        check_eq("arb_if_acc",   {31'd0, busy},        32'd1);
        check_eq("arb_if_ram_a", ram_a,                32'h0000_1000);
        check_eq("arb_tag_clr",  {30'd0, if_or_mem_o}, 32'd0);
        if_request = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check_eq("arb_if_tag",   {30'd0, if_or_mem_o}, 32'd1);
        check_eq("arb_if_rdata", rdata,                32'h0010_0513);

        // ---------------- halfword store, inputs change after acceptance
        mem_request = 1'b1;
        mem_we      = 1'b1;
        mem_addr    = 32'h0000_0030;
        mem_wdata   = 32'hDEAD_BEEF;
        mem_len     = 2'b01;
        tick();
        check_eq("st0_wr",   {31'd0, ram_wr},   32'd1);
        check_eq("st0_a",    ram_a,             32'h0000_0030);
        check_eq("st0_dout", {24'd0, ram_dout}, 32'h0000_00EF);
        mem_request = 1'b0;
        mem_addr    = 32'h0000_0099;
        mem_wdata   = 32'h1234_5678;
        tick();
        check_eq("st1_wr",   {31'd0, ram_wr},   32'd1);
        check_eq("st1_a",    ram_a,             32'h0000_0031);
        check_eq("st1_dout", {24'd0, ram_dout}, 32'h0000_00BE);
        check_eq("st1_tag",  {30'd0, if_or_mem_o}, 32'd0);
        tick();
        check_eq("st_done_wr",    {31'd0, ram_wr},      32'd0);
        check_eq("st_done_tag",   {30'd0, if_or_mem_o}, 32'd2);
        check_eq("st_done_busy",  {31'd0, busy},        32'd0);
        check_eq("st_done_rdata", rdata,                32'h0010_0513);
        check_eq("st_done_dout",  {24'd0, ram_dout},    32'd0);
        tick();

        // ---------------- wrapping word load; request held, address changed
        mem_request = 1'b1;
        mem_we      = 1'b0;
        mem_addr    = 32'hFFFF_FFFE;
        mem_len     = 2'b10;
        tick();
        check_eq("wrap_a0", ram_a, 32'hFFFF_FFFE);
        mem_addr = 32'h0000_0040;
        mem_len  = 2'b00;
        tick();
        check_eq("wrap_a1", ram_a, 32'hFFFF_FFFF);
        tick();
        check_eq("wrap_a2", ram_a, 32'h0000_0000);
        check_eq("wrap_busy", {31'd0, busy}, 32'd1);
        tick();
        check_eq("wrap_a3", ram_a, 32'h0000_0001);
        tick();
        check_eq("wrap_tag",   {30'd0, if_or_mem_o}, 32'd2);
        check_eq("wrap_rdata", rdata,                32'h4433_2211);
        check_eq("wrap_busy0", {31'd0, busy},        32'd0);
        tick();
        // still-held request now taken with the new address and length
        check_eq("reacc_busy", {31'd0, busy}, 32'd1);
        check_eq("reacc_a",    ram_a,         32'h0000_0040);
        mem_request = 1'b0;
        tick();
        check_eq("reacc_tag",   {30'd0, if_or_mem_o}, 32'd2);
        check_eq("reacc_rdata", rdata,                32'h0000_005A);
        tick();

        // ---------------- reset in the middle of an IF fetch
        if_request = 1'b1;
        if_addr    = 32'h0000_1000;
        tick();
        if_request = 1'b0;
        tick();
        check_eq("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        check_eq("mid_rst_busy",  {31'd0, busy},        32'd0);
        check_eq("mid_rst_wr",    {31'd0, ram_wr},      32'd0);
        check_eq("mid_rst_tag",   {30'd0, if_or_mem_o}, 32'd0);
        check_eq("mid_rst_rdata", rdata,                32'd0);
        check_eq("mid_rst_ram_a", ram_a,                32'd0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq("post_rst_tag",  {30'd0, if_or_mem_o}, 32'd0);
            check_eq("post_rst_busy", {31'd0, busy},        32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset. Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous reset, active-high (`RstEnable`).
- if_request  in  1  IF wants a 4-byte instruction fetch.
- if_addr  in  32  IF fetch byte address.
- mem_request  in  1  MEM stage wants a load/store.
- mem_we  in  1  0 = load, 1 = store.
- mem_addr  in  32  MEM byte address.
- mem_wdata  in  32  store data; byte 0 = bits 7:0.
- mem_len  in  2  00 = 1 byte, 01 = 2 bytes, 10/11 = 4 bytes.
- ram_din  in  8  RAM read byte; valid the cycle after its address.
- ram_dout  out  8  RAM write byte.
- ram_a  out  32  RAM byte address.
- ram_wr  out  1  RAM write enable.
- busy  out  1  transaction in progress.
- if_or_mem_o  out  2  one-cycle completion tag: 01 = IF, 10 = MEM, 00 = none.
- rdata  out  32  assembled read data.
- pc_back  out  32  fetched address + 4.

Function
REQ-002 FSM states SHALL be IDLE, READ, WRITE; busy = 1 exactly when state is not IDLE.
REQ-003 In IDLE at a rising edge, the arbiter SHALL accept one request. MEM wins over IF when both are high.
REQ-004 On acceptance, the arbiter SHALL latch address, byte count N (1/2/4), write data and owner. Later input changes SHALL be ignored until completion.
REQ-005 Requests arriving while busy = 1 SHALL be ignored, not queued. Requesters hold their request until served.
REQ-006 Read accepted at edge c: after edge c+k (0 <= k < N), ram_a SHALL equal base+k and ram_wr = 0.
REQ-007 Read data capture: the byte on ram_din SHALL be captured at edge c+k+1 into rdata byte lane k. Lanes above N-1 SHALL be zero-filled.
REQ-008 At edge c+N the block SHALL, together: update rdata, set if_or_mem_o to the owner tag, drop busy to 0, return to IDLE.
REQ-009 Write accepted at edge c: after edge c+k (k < N), ram_wr = 1, ram_a = base+k, ram_dout = mem_wdata byte k.
REQ-010 Write completion at edge c+N: ram_wr SHALL return to 0, if_or_mem_o = 10, busy = 0, state IDLE.
REQ-011 IF requests SHALL always be 4-byte reads, regardless of mem_len. mem_we applies only to MEM.
REQ-012 if_or_mem_o SHALL be non-zero for exactly one cycle per completion, and 00 otherwise.
REQ-013 On IF completion, pc_back SHALL be latched if_addr + 4 (mod 2^32). Otherwise it SHALL hold its value.
REQ-014 rdata SHALL hold its value until the next read completion. Write completions SHALL NOT alter rdata.
REQ-015 Address increments SHALL wrap modulo 2^32, e.g. base 0xFFFFFFFE, N = 4 gives 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
REQ-016 In IDLE: ram_wr = 0, ram_a = 0, ram_dout = 0.
REQ-017 The earliest next acceptance after a completion at edge c+N SHALL be edge c+N+1. No back-to-back acceptance on the completion edge.

Reset
REQ-018 With rst = 1 at an edge, the block SHALL go to IDLE and set busy = 0, if_or_mem_o = 00, rdata = 0, pc_back = 0, ram_a = 0, ram_dout = 0, ram_wr = 0.
REQ-019 Reset mid-transaction SHALL abort the transaction: no completion pulse, and ram_wr = 0 from the reset edge onward.
REQ-020 Requests held high during reset SHALL NOT be accepted. The earliest acceptance SHALL be the first edge with rst = 0.

Verification
REQ-021 IF fetch: if_addr = 0x1000, RAM bytes 0x13,0x05,0x10,0x00.
  -> ram_a sequence 0x1000..0x1003; after 4 cycles rdata = 0x00100513, if_or_mem_o = 01 for one cycle, pc_back = 0x1004, busy 1 -> 0.
REQ-022 Simultaneous requests: if_request = 1 and mem_request = 1 (load, 1 byte, 0x20, RAM = 0xAB).
  -> MEM served first: rdata = 0x000000AB, tag 10. IF is accepted the cycle after completion.
REQ-023 Halfword store: mem_addr = 0x30, mem_wdata = 0xDEADBEEF, mem_len = 01.
  -> ram_wr = 1 for 2 cycles, (0x30, 0xEF) then (0x31, 0xBE); tag 10; rdata unchanged.
REQ-024 Reset mid-fetch: rst asserted after byte 1 of an IF fetch.
  -> busy = 0, ram_wr = 0, no tag pulse, rdata = 0.
REQ-025 Address wrap: word load at 0xFFFFFFFE.
  -> ram_a sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001.
REQ-026 Request changes mid-transaction: mem_addr changed during an accepted transaction.
  -> the latched address is still used; no second acceptance while busy = 1.
